// File: rtl/tuner_phy_pkg.sv
// tuner_phy_pkg
// Shared types and default parameters for the tuner search/lock controller.
// Contents:
//   ctrl_state_e      - controller FSM state encoding
//   *_DEF localparams - default widths, peak count, retry limit and watchdog limit
//   idx_width()       - width of an index into NUM_TARGET entries, never less than 1
package tuner_phy_pkg;

    localparam int DAC_WIDTH_DEF      = 8;
    localparam int ADC_WIDTH_DEF      = 8;
    localparam int NUM_TARGET_DEF     = 4;
    localparam int MAX_RETRY_DEF      = 3;
    localparam int TIMEOUT_CYCLES_DEF = 4096;

    typedef enum logic [3:0] {
        IDLE        = 4'd0,
        SEARCH_TRIG = 4'd1,
        SEARCH_WAIT = 4'd2,
        SELECT      = 4'd3,
        LOCK_TRIG   = 4'd4,
        LOCKED      = 4'd5,
        INTR_ACK    = 4'd6,
        RESUME      = 4'd7,
        ERR         = 4'd8
    } ctrl_state_e;

    // A single-entry table still needs a 1-bit index signal.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tuner_peak_select.sv
// tuner_peak_select
// Combinational argmax over the power codes of a peak table. Only the first
// i_cnt entries take part. On equal power the lowest index wins.
// Ports:
//   i_pwr   - power code per table entry
//   i_cnt   - number of valid leading entries
//   o_idx   - index of the strongest valid entry
//   o_valid - 1 when i_cnt is in 1..NUM_TARGET
module tuner_peak_select
    import tuner_phy_pkg::*;
#(
    parameter int NUM_TARGET = NUM_TARGET_DEF,
    parameter int ADC_WIDTH  = ADC_WIDTH_DEF,
    localparam int IDX_W     = idx_width(NUM_TARGET),
    localparam int CNT_W     = $clog2(NUM_TARGET) + 1
) (
    input  logic [NUM_TARGET-1:0][ADC_WIDTH-1:0] i_pwr,
    input  logic [CNT_W-1:0]                     i_cnt,
    output logic [IDX_W-1:0]                     o_idx,
    output logic                                 o_valid
);

    logic [ADC_WIDTH-1:0] best_pwr;

    // Strict greater-than keeps the earliest index on ties. Entry 0 is the
    // starting candidate; o_valid flags the case where it is not really valid.
    always_comb begin
        o_idx    = '0;
        best_pwr = i_pwr[0];
        for (int i = 1; i < NUM_TARGET; i++) begin
            if ((i < int'(i_cnt)) && (i_pwr[i] > best_pwr)) begin
                o_idx    = IDX_W'(i);
                best_pwr = i_pwr[i];
            end
        end
        o_valid = (i_cnt != '0) && (i_cnt <= CNT_W'(NUM_TARGET));
    end

endmodule

// File: rtl/tuner_search_lock_ctrl.sv
// tuner_search_lock_ctrl
// The controller asks a peak search engine for resonance peaks. It picks the
// strongest peak, then triggers and maintains a lock on that peak. After a
// lock-loss interrupt it resumes the lock. It gives up after too many
// interrupts.
//
// Optional feature: define TUNER_CTRL_TIMEOUT_EN to add a watchdog. The
// watchdog forces ERR when a handshake state waits TIMEOUT_CYCLES cycles.
//
// Ports:
//   i_clk, i_rst_n                             - clock, async active-low reset
//   i_start                                    - level request to search and lock
//   i_clr                                      - pulse that leaves ERR
//   o_search_trig_val / i_search_trig_rdy      - search trigger handshake
//   i_search_peaks_val / o_search_peaks_rdy    - peak table handshake
//   i_ring_tune_peaks, i_pwr_peaks,
//   i_peaks_cnt                                - peak table and its valid count
//   o_lock_trig_val / i_lock_trig_rdy          - lock trigger handshake
//   i_lock_intr_val / o_lock_intr_rdy          - lock-loss interrupt handshake
//   o_lock_resume_val / i_lock_resume_rdy      - lock resume handshake
//   o_cfg_ring_tune_peak, o_cfg_pwr_peak       - selected lock target
//   o_state, o_locked, o_err, o_retry_cnt      - status
module tuner_search_lock_ctrl
    import tuner_phy_pkg::*;
#(
    parameter int DAC_WIDTH  = DAC_WIDTH_DEF,
    parameter int ADC_WIDTH  = ADC_WIDTH_DEF,
    parameter int NUM_TARGET = NUM_TARGET_DEF,
    parameter int MAX_RETRY  = MAX_RETRY_DEF
`ifdef TUNER_CTRL_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
`endif
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst_n,
    input  logic                                 i_start,
    input  logic                                 i_clr,
    output logic                                 o_search_trig_val,
    input  logic                                 i_search_trig_rdy,
    input  logic                                 i_search_peaks_val,
    output logic                                 o_search_peaks_rdy,
    input  logic [NUM_TARGET-1:0][DAC_WIDTH-1:0] i_ring_tune_peaks,
    input  logic [NUM_TARGET-1:0][ADC_WIDTH-1:0] i_pwr_peaks,
    input  logic [$clog2(NUM_TARGET):0]          i_peaks_cnt,
    output logic                                 o_lock_trig_val,
    input  logic                                 i_lock_trig_rdy,
    input  logic                                 i_lock_intr_val,
    output logic                                 o_lock_intr_rdy,
    output logic                                 o_lock_resume_val,
    input  logic                                 i_lock_resume_rdy,
    output logic [DAC_WIDTH-1:0]                 o_cfg_ring_tune_peak,
    output logic [ADC_WIDTH-1:0]                 o_cfg_pwr_peak,
    output ctrl_state_e                          o_state,
    output logic                                 o_locked,
    output logic                                 o_err,
    output logic [$clog2(MAX_RETRY+1)-1:0]       o_retry_cnt
);

    localparam int IDX_W   = idx_width(NUM_TARGET);
    localparam int CNT_W   = $clog2(NUM_TARGET) + 1;
    localparam int RETRY_W = $clog2(MAX_RETRY + 1);

    ctrl_state_e                          state_q, state_d;
    logic [NUM_TARGET-1:0][DAC_WIDTH-1:0] tune_q;
    logic [NUM_TARGET-1:0][ADC_WIDTH-1:0] pwr_q;
    logic [CNT_W-1:0]                     cnt_q;
    logic [DAC_WIDTH-1:0]                 cfg_tune_q, cfg_tune_d;
    logic [ADC_WIDTH-1:0]                 cfg_pwr_q, cfg_pwr_d;
    logic [RETRY_W-1:0]                   retry_q, retry_d;
    logic search_trig_val_q, search_peaks_rdy_q, lock_trig_val_q;
    logic lock_intr_rdy_q, lock_resume_val_q, locked_q, err_q;
    logic [IDX_W-1:0]                     sel_idx;
    logic                                 sel_valid;
    logic                                 tmo_hit;

    tuner_peak_select #(
        .NUM_TARGET (NUM_TARGET),
        .ADC_WIDTH  (ADC_WIDTH)
    ) u_peak_select (
        .i_pwr   (pwr_q),
        .i_cnt   (cnt_q),
        .o_idx   (sel_idx),
        .o_valid (sel_valid)
    );

`ifdef TUNER_CTRL_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES);

    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             tmo_active;

    // The watchdog counts only in states that wait on the far side of a
    // handshake. It fires on the last allowed cycle of that state.
    always_comb begin
        tmo_active = (state_q == SEARCH_TRIG) || (state_q == SEARCH_WAIT) ||
                     (state_q == LOCK_TRIG)   || (state_q == RESUME);
        tmo_hit    = tmo_active && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
        tmo_d      = (tmo_active && (state_d == state_q)) ? tmo_q + 1'b1 : '0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) tmo_q <= '0;
        else          tmo_q <= tmo_d;
    end
`else
    assign tmo_hit = 1'b0;
`endif

    // When i_start drops, the controller returns to IDLE. States that drive
    // a val signal first finish their handshake, so val never drops early.
    always_comb begin
        state_d    = state_q;
        cfg_tune_d = cfg_tune_q;
        cfg_pwr_d  = cfg_pwr_q;
        retry_d    = retry_q;
        case (state_q)
            IDLE:        if (i_start) state_d = SEARCH_TRIG;
            SEARCH_TRIG: if (i_search_trig_rdy) state_d = i_start ? SEARCH_WAIT : IDLE;
            SEARCH_WAIT: begin
                if (!i_start)                state_d = IDLE;
                else if (i_search_peaks_val) state_d = SELECT;
            end
            SELECT: begin
                if (!sel_valid) begin
                    state_d = ERR;
                end else begin
                    cfg_tune_d = tune_q[sel_idx];
                    cfg_pwr_d  = pwr_q[sel_idx];
                    state_d    = i_start ? LOCK_TRIG : IDLE;
                end
            end
            LOCK_TRIG:   if (i_lock_trig_rdy) state_d = i_start ? LOCKED : IDLE;
            LOCKED: begin
                if (!i_start)             state_d = IDLE;
                else if (i_lock_intr_val) state_d = INTR_ACK;
            end
            INTR_ACK: begin
                // The counter saturates. An interrupt that arrives at the
                // limit is the one that would push past MAX_RETRY.
                if (retry_q == RETRY_W'(MAX_RETRY)) begin
                    state_d = ERR;
                end else begin
                    retry_d = retry_q + 1'b1;
                    state_d = i_start ? RESUME : IDLE;
                end
            end
            RESUME:      if (i_lock_resume_rdy) state_d = i_start ? LOCKED : IDLE;
            ERR:         if (i_clr) state_d = IDLE;
            default:     state_d = IDLE;
        endcase
        if (tmo_hit && (state_d == state_q)) state_d = ERR;
        if ((state_d == SEARCH_TRIG) && (state_q != SEARCH_TRIG)) retry_d = '0;
    end

    // The handshake and status outputs are flops. Each one is decoded from
    // the next state, so it changes in the same cycle as the state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q            <= IDLE;
            cfg_tune_q         <= '0;
            cfg_pwr_q          <= '0;
            retry_q            <= '0;
            search_trig_val_q  <= 1'b0;
            search_peaks_rdy_q <= 1'b0;
            lock_trig_val_q    <= 1'b0;
            lock_intr_rdy_q    <= 1'b0;
            lock_resume_val_q  <= 1'b0;
            locked_q           <= 1'b0;
            err_q              <= 1'b0;
        end else begin
            state_q            <= state_d;
            cfg_tune_q         <= cfg_tune_d;
            cfg_pwr_q          <= cfg_pwr_d;
            retry_q            <= retry_d;
            search_trig_val_q  <= (state_d == SEARCH_TRIG);
            search_peaks_rdy_q <= (state_d == SEARCH_WAIT);
            lock_trig_val_q    <= (state_d == LOCK_TRIG);
            lock_intr_rdy_q    <= (state_d == LOCKED);
            lock_resume_val_q  <= (state_d == RESUME);
            locked_q           <= (state_d == LOCKED);
            err_q              <= (state_d == ERR);
        end
    end

    // The peak table is captured when its handshake completes. SELECT then
    // works on a stable copy while the search engine moves on.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tune_q <= '0;
            pwr_q  <= '0;
            cnt_q  <= '0;
        end else if ((state_q == SEARCH_WAIT) && i_search_peaks_val) begin
            tune_q <= i_ring_tune_peaks;
            pwr_q  <= i_pwr_peaks;
            cnt_q  <= i_peaks_cnt;
        end
    end

    assign o_search_trig_val    = search_trig_val_q;
    assign o_search_peaks_rdy   = search_peaks_rdy_q;
    assign o_lock_trig_val      = lock_trig_val_q;
    assign o_lock_intr_rdy      = lock_intr_rdy_q;
    assign o_lock_resume_val    = lock_resume_val_q;
    assign o_cfg_ring_tune_peak = cfg_tune_q;
    assign o_cfg_pwr_peak       = cfg_pwr_q;
    assign o_state              = state_q;
    assign o_locked             = locked_q;
    assign o_err                = err_q;
    assign o_retry_cnt          = retry_q;

endmodule

// File: tb/tb_tuner_search_lock_ctrl.sv
// tb_tuner_search_lock_ctrl
// Testbench for tuner_search_lock_ctrl.
// Each stimulus task pushes the response it expects onto expQ. The monitor
// pops and compares an entry whenever the DUT completes a search trigger,
// a lock trigger or a resume handshake, or whenever it raises o_err.
// Other properties are compared directly: reset values, val hold, ERR
// stickiness, and watchdog behaviour (which depends on TUNER_CTRL_TIMEOUT_EN).
module tb_tuner_search_lock_ctrl;
    import tuner_phy_pkg::*;

    localparam int SEL_STRIG  = 0;
    localparam int SEL_PRDY   = 1;
    localparam int SEL_IRDY   = 2;
    localparam int SEL_RESUME = 3;
    localparam int SEL_LOCKED = 4;
    localparam int SEL_ERR    = 5;

    typedef enum int {EV_STRIG, EV_LTRIG, EV_RESUME, EV_ERR} ev_e;
    typedef struct {
        ev_e         kind;
        int unsigned value;
        string       name;
    } exp_t;

    logic             i_clk, i_rst_n, i_start, i_clr;
    logic             o_search_trig_val, i_search_trig_rdy;
    logic             i_search_peaks_val, o_search_peaks_rdy;
    logic [3:0][7:0]  i_ring_tune_peaks, i_pwr_peaks;
    logic [2:0]       i_peaks_cnt;
    logic             o_lock_trig_val, i_lock_trig_rdy;
    logic             i_lock_intr_val, o_lock_intr_rdy;
    logic             o_lock_resume_val, i_lock_resume_rdy;
    logic [7:0]       o_cfg_ring_tune_peak, o_cfg_pwr_peak;
    ctrl_state_e      o_state;
    logic             o_locked, o_err;
    logic [1:0]       o_retry_cnt;

    int   checks   = 0;
    int   failures = 0;
    exp_t expQ[$];
    logic prevErr  = 1'b0;

    tuner_search_lock_ctrl dut (
        .i_clk                (i_clk),
        .i_rst_n              (i_rst_n),
        .i_start              (i_start),
        .i_clr                (i_clr),
        .o_search_trig_val    (o_search_trig_val),
        .i_search_trig_rdy    (i_search_trig_rdy),
        .i_search_peaks_val   (i_search_peaks_val),
        .o_search_peaks_rdy   (o_search_peaks_rdy),
        .i_ring_tune_peaks    (i_ring_tune_peaks),
        .i_pwr_peaks          (i_pwr_peaks),
        .i_peaks_cnt          (i_peaks_cnt),
        .o_lock_trig_val      (o_lock_trig_val),
        .i_lock_trig_rdy      (i_lock_trig_rdy),
        .i_lock_intr_val      (i_lock_intr_val),
        .o_lock_intr_rdy      (o_lock_intr_rdy),
        .o_lock_resume_val    (o_lock_resume_val),
        .i_lock_resume_rdy    (i_lock_resume_rdy),
        .o_cfg_ring_tune_peak (o_cfg_ring_tune_peak),
        .o_cfg_pwr_peak       (o_cfg_pwr_peak),
        .o_state              (o_state),
        .o_locked             (o_locked),
        .o_err                (o_err),
        .o_retry_cnt          (o_retry_cnt)
    );

    // 10-unit clock period.
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Absolute time bound so the run always ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [24:0] outVec();
        return {o_search_trig_val, o_search_peaks_rdy, o_lock_trig_val, o_lock_intr_rdy,
                o_lock_resume_val, o_locked, o_err, o_retry_cnt,
                o_cfg_ring_tune_peak, o_cfg_pwr_peak};
    endfunction

    function automatic logic pick(input int sel);
        case (sel)
            SEL_STRIG:  return o_search_trig_val;
            SEL_PRDY:   return o_search_peaks_rdy;
            SEL_IRDY:   return o_lock_intr_rdy;
            SEL_RESUME: return o_lock_resume_val;
            SEL_LOCKED: return o_state == LOCKED;
            default:    return o_state == ERR;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Waits a bounded number of cycles for a DUT condition. If the bound
    // expires, the wait counts as a failed comparison.
    task automatic waitHigh(input int sel, input int maxCycles, input string name);
        for (int i = 0; i < maxCycles; i++) begin
            if (pick(sel)) return;
            tick();
        end
        checks++;
        failures++;
        $display("[TB] FAIL %s: condition %0d still low after %0d cycles", name, sel, maxCycles);
    endtask

    task automatic expectEvent(input ev_e kind, input int unsigned value, input string name);
        exp_t e;
        e.kind  = kind;
        e.value = value;
        e.name  = name;
        expQ.push_back(e);
    endtask

    // Presents one peak table on the peak handshake and records the
    // response expected from the DUT.
    task automatic applyStimulus(input int cnt,
                                 input logic [7:0] p0, input logic [7:0] p1,
                                 input logic [7:0] p2, input logic [7:0] p3,
                                 input logic [7:0] t0, input logic [7:0] t1,
                                 input logic [7:0] t2, input logic [7:0] t3,
                                 input ev_e kind, input int unsigned value, input string name);
        expectEvent(kind, value, name);
        waitHigh(SEL_PRDY, 20, {name, "PeaksRdy"});
        i_pwr_peaks[0] = p0; i_pwr_peaks[1] = p1; i_pwr_peaks[2] = p2; i_pwr_peaks[3] = p3;
        i_ring_tune_peaks[0] = t0; i_ring_tune_peaks[1] = t1;
        i_ring_tune_peaks[2] = t2; i_ring_tune_peaks[3] = t3;
        i_peaks_cnt        = 3'(cnt);
        i_search_peaks_val = 1'b1;
        tick();
        i_search_peaks_val = 1'b0;
    endtask

    task automatic pulseIntr(input string name);
        waitHigh(SEL_IRDY, 20, {name, "IntrRdy"});
        i_lock_intr_val = 1'b1;
        tick();
        i_lock_intr_val = 1'b0;
    endtask

    task automatic pulseClr();
        i_clr = 1'b1;
        tick();
        i_clr = 1'b0;
    endtask

    task automatic scoreEvent(input ev_e kind, input int unsigned actual);
        exp_t e;
        checks++;
        if (expQ.size() == 0) begin
            failures++;
            $display("[TB] FAIL unexpectedEvent: event %0d value %0d with empty queue", kind, actual);
        end else begin
            e = expQ.pop_front();
            if ((e.kind != kind) || (e.value != actual)) begin
                failures++;
                $display("[TB] FAIL %s: got event %0d value 0x%0h expected event %0d value 0x%0h",
                         e.name, kind, actual, e.kind, e.value);
            end
        end
    endtask

    // Monitor: a completed handshake or a rising o_err pops one expectation.
    always @(negedge i_clk) begin
        if (!i_rst_n) begin
            prevErr = 1'b0;
        end else begin
            if (o_search_trig_val && i_search_trig_rdy)
                scoreEvent(EV_STRIG, 32'(o_retry_cnt));
            if (o_lock_trig_val && i_lock_trig_rdy)
                scoreEvent(EV_LTRIG, {16'd0, o_cfg_ring_tune_peak, o_cfg_pwr_peak});
            if (o_lock_resume_val && i_lock_resume_rdy)
                scoreEvent(EV_RESUME, 32'(o_retry_cnt));
            if (o_err && !prevErr)
                scoreEvent(EV_ERR, 32'(o_retry_cnt));
            prevErr = o_err;
        end
    end

    initial begin
        i_rst_n = 1'b1; i_start = 1'b0; i_clr = 1'b0;
        i_search_trig_rdy = 1'b0; i_search_peaks_val = 1'b0;
        i_ring_tune_peaks = '0; i_pwr_peaks = '0; i_peaks_cnt = '0;
        i_lock_trig_rdy = 1'b0; i_lock_intr_val = 1'b0; i_lock_resume_rdy = 1'b0;
        #1 i_rst_n = 1'b0;
        repeat (2) @(negedge i_clk);
        checkOutput("resetOutputs", 32'(outVec()), 32'd0);
        checkOutput("resetState", 32'(o_state), 32'(IDLE));
        i_rst_n = 1'b1;
        tick();
        @(negedge i_clk);
        checkOutput("postResetQuiet", 32'(outVec()), 32'd0);

        // Search trigger is held with rdy low for 10 cycles.
        expectEvent(EV_STRIG, 0, "trigFirst");
        i_start = 1'b1;
        waitHigh(SEL_STRIG, 5, "trigWait");
        for (int k = 0; k < 10; k++) begin
            @(negedge i_clk);
            checkOutput($sformatf("trigHold%0d", k), 32'(o_search_trig_val), 32'd1);
        end
        tick();
        i_search_trig_rdy = 1'b1;
        tick();
        i_search_trig_rdy = 1'b0;
        @(negedge i_clk);
        checkOutput("trigDrop", 32'(o_search_trig_val), 32'd0);
        checkOutput("peaksRdy", 32'(o_search_peaks_rdy), 32'd1);

        // Selection with a tie between entries 1 and 2. Entry 1 must win.
        i_lock_trig_rdy   = 1'b1;
        i_lock_resume_rdy = 1'b1;
        applyStimulus(3, 8'd40, 8'd90, 8'd90, 8'd10, 8'd20, 8'd60, 8'd80, 8'd0,
                      EV_LTRIG, 32'h3C5A, "selTie");
        waitHigh(SEL_LOCKED, 10, "lockTie");
        @(negedge i_clk);
        checkOutput("cfgTune", 32'(o_cfg_ring_tune_peak), 32'd60);
        checkOutput("cfgPwr", 32'(o_cfg_pwr_peak), 32'd90);
        checkOutput("lockedFlag", 32'(o_locked), 32'd1);
        pulseClr();
        @(negedge i_clk);
        checkOutput("clrIgnored", 32'(o_state), 32'(LOCKED));

        // Three interrupts are resumed. The fourth one ends in ERR.
        for (int n = 1; n <= 3; n++) begin
            expectEvent(EV_RESUME, n, $sformatf("resume%0d", n));
            pulseIntr($sformatf("intr%0d", n));
            waitHigh(SEL_LOCKED, 10, $sformatf("relock%0d", n));
        end
        @(negedge i_clk);
        checkOutput("retry3", 32'(o_retry_cnt), 32'd3);
        checkOutput("relocked", 32'(o_locked), 32'd1);
        expectEvent(EV_ERR, 3, "retryExhausted");
        pulseIntr("intr4");
        waitHigh(SEL_ERR, 10, "errWait");
        @(negedge i_clk);
        checkOutput("errFlag", 32'(o_err), 32'd1);
        checkOutput("errQuiet", 32'({o_search_trig_val, o_search_peaks_rdy, o_lock_trig_val,
                                     o_lock_intr_rdy, o_lock_resume_val, o_locked}), 32'd0);
        repeat (3) tick();
        checkOutput("errSticky", 32'(o_state), 32'(ERR));

        // Clearing ERR restarts the search because i_start is still high.
        // A peak count of 0 is rejected.
        i_search_trig_rdy = 1'b1;
        expectEvent(EV_STRIG, 0, "trigAfterClr");
        pulseClr();
        @(negedge i_clk);
        checkOutput("clrToIdle", 32'(o_state), 32'(IDLE));
        applyStimulus(0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, EV_ERR, 0, "cnt0");
        waitHigh(SEL_ERR, 10, "cnt0Err");
        @(negedge i_clk);
        checkOutput("cfgHeldTune", 32'(o_cfg_ring_tune_peak), 32'd60);
        checkOutput("cfgHeldPwr", 32'(o_cfg_pwr_peak), 32'd90);

        // A peak count above NUM_TARGET is rejected.
        expectEvent(EV_STRIG, 0, "trigCnt5");
        pulseClr();
        applyStimulus(5, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, EV_ERR, 0, "cnt5");
        waitHigh(SEL_ERR, 10, "cnt5Err");

        // A full table whose maximum is in the last entry.
        expectEvent(EV_STRIG, 0, "trigLast");
        pulseClr();
        applyStimulus(4, 8'd10, 8'd20, 8'd30, 8'd200, 8'd1, 8'd2, 8'd3, 8'd4,
                      EV_LTRIG, 32'h04C8, "selLast");
        waitHigh(SEL_LOCKED, 10, "lockLast");

        // Dropping i_start while LOCKED returns to IDLE.
        i_start = 1'b0;
        tick();
        @(negedge i_clk);
        checkOutput("abortIdle", 32'(o_state), 32'(IDLE));
        checkOutput("abortUnlocked", 32'(o_locked), 32'd0);

        // The count masks out stronger entries beyond the first two.
        expectEvent(EV_STRIG, 0, "trigMask");
        i_start = 1'b1;
        applyStimulus(2, 8'd5, 8'd9, 8'd250, 8'd250, 8'd11, 8'd22, 8'd33, 8'd44,
                      EV_LTRIG, 32'h1609, "selMask");
        waitHigh(SEL_LOCKED, 10, "lockMask");

        // Reset asserted in the middle of RESUME.
        i_lock_resume_rdy = 1'b0;
        pulseIntr("intrRst");
        waitHigh(SEL_RESUME, 10, "resumeWait");
        @(posedge i_clk);
        #2 i_rst_n = 1'b0;
        #1;
        checkOutput("rstOutputs", 32'(outVec()), 32'd0);
        checkOutput("rstState", 32'(o_state), 32'(IDLE));
        repeat (2) @(negedge i_clk);
        i_lock_resume_rdy = 1'b1;
        expectEvent(EV_STRIG, 0, "trigAfterRst");
        i_rst_n = 1'b1;

        // No peak table ever arrives.
        waitHigh(SEL_PRDY, 10, "tmoPeaksRdy");
`ifdef TUNER_CTRL_TIMEOUT_EN
        begin
            int waitCycles;
            waitCycles = 0;
            expectEvent(EV_ERR, 0, "tmoErr");
            for (int i = 0; i < 5000; i++) begin
                @(negedge i_clk);
                if (o_state != SEARCH_WAIT) break;
                waitCycles++;
            end
            checkOutput("tmoCycles", 32'(waitCycles), 32'd4096);
            checkOutput("tmoState", 32'(o_state), 32'(ERR));
        end
`else
        repeat (10000) @(negedge i_clk);
        checkOutput("noTmoState", 32'(o_state), 32'(SEARCH_WAIT));
`endif

        repeat (3) tick();
        checkOutput("scoreboardDrained", 32'(expQ.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
